// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard detection and forwarding control for a five-stage MIPS-style
// pipeline (F, D, E, M, W). It tracks the register indices of the
// instructions in E, M and W and the cycles left before each result exists.
// From these it decides whether the instruction in D must stall, and where
// each operand in D, E and M should be taken from.
//
// Ports
//   clk         in   1   single clock, all state updates on posedge
//   reset       in   1   asynchronous, active-high
//   A1_D        in   5   rs index of the instruction in D
//   A2_D        in   5   rt index of the instruction in D
//   A3_D        in   5   destination index of the instruction in D
//   regwrite_D  in   1   D instruction writes the register file
//   tnew_D      in   2   cycles until the D result exists, counted from E entry
//   tuse_rs0    in   1   rs is read in D
//   tuse_rs1    in   1   rs is read in E
//   tuse_rt0    in   1   rt is read in D
//   tuse_rt1    in   1   rt is read in E
//   stall       out  1   freeze PC and F/D, inject a bubble into E
//   fwd_rs_D    out  2   D rs source: 0 regfile, 1 E, 2 M, 3 W
//   fwd_rt_D    out  2   D rt source: 0 regfile, 1 E, 2 M, 3 W
//   fwd_rs_E    out  2   E rs source: 0 pipe reg, 2 M, 3 W
//   fwd_rt_E    out  2   E rt source: 0 pipe reg, 2 M, 3 W
//   fwd_rt_M    out  1   M store data taken from W
//   stall_cnt   out  32  saturating count of stalled cycles
// ---------------------------------------------------------------------------
module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1_D,
    input  logic [4:0]  A2_D,
    input  logic [4:0]  A3_D,
    input  logic        regwrite_D,
    input  logic [1:0]  tnew_D,
    input  logic        tuse_rs0,
    input  logic        tuse_rs1,
    input  logic        tuse_rt0,
    input  logic        tuse_rt1,
    output logic        stall,
    output logic [1:0]  fwd_rs_D,
    output logic [1:0]  fwd_rt_D,
    output logic [1:0]  fwd_rs_E,
    output logic [1:0]  fwd_rt_E,
    output logic        fwd_rt_M,
    output logic [31:0] stall_cnt
);

    // Forwarding source encodings
    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_E    = 2'd1;
    localparam logic [1:0] FWD_M    = 2'd2;
    localparam logic [1:0] FWD_W    = 2'd3;

    // -----------------------------------------------------------------------
    // Stage registers
    // -----------------------------------------------------------------------
    logic [4:0]  r_a1_e;
    logic [4:0]  r_a2_e;
    logic [4:0]  r_a3_e;
    logic [1:0]  r_tnew_e;
    logic [4:0]  r_a2_m;
    logic [4:0]  r_a3_m;
    logic [1:0]  r_tnew_m;
    logic [4:0]  r_a3_w;
    logic [31:0] r_stall_cnt;

    logic [4:0]  w_a3_eff;
    logic [1:0]  w_tnew_m_next;
    logic        w_stall_rs;
    logic        w_stall_rt;

    // Instructions that do not write the register file carry destination 0,
    // which never matches any source.
    assign w_a3_eff = regwrite_D ? A3_D : 5'd0;

    // The result gets one cycle closer each stage, bottoming out at 0.
    assign w_tnew_m_next = (r_tnew_e == 2'd0) ? 2'd0 : r_tnew_e - 2'd1;

    // -----------------------------------------------------------------------
    // Stall detection
    // -----------------------------------------------------------------------
    // A read in D needs a value ready now; a read in E gets one extra cycle,
    // so it only stalls against an E producer that needs two or more.
    function automatic logic stall_term(
        input logic [4:0] src,
        input logic       use0,
        input logic       use1,
        input logic [4:0] a3_e,
        input logic [1:0] tnew_e,
        input logic [4:0] a3_m,
        input logic [1:0] tnew_m
    );
        logic hit_e;
        logic hit_m;
        hit_e = (src != 5'd0) && (src == a3_e);
        hit_m = (src != 5'd0) && (src == a3_m);
        stall_term = (use0 && hit_e && (tnew_e > 2'd0)) ||
                     (use0 && hit_m && (tnew_m > 2'd0)) ||
                     (use1 && hit_e && (tnew_e > 2'd1));
    endfunction

    always_comb begin
        w_stall_rs = stall_term(A1_D, tuse_rs0, tuse_rs1, r_a3_e, r_tnew_e, r_a3_m, r_tnew_m);
        w_stall_rt = stall_term(A2_D, tuse_rt0, tuse_rt1, r_a3_e, r_tnew_e, r_a3_m, r_tnew_m);
        stall      = w_stall_rs || w_stall_rt;
    end

    // -----------------------------------------------------------------------
    // Forwarding selection
    // -----------------------------------------------------------------------
    // The newest matching stage owns the register. If that stage has not yet
    // produced the value the answer is "none": older copies are stale and
    // the stall logic holds the consumer back.
    function automatic logic [1:0] fwd_sel_d(
        input logic [4:0] src,
        input logic [4:0] a3_e,
        input logic [1:0] tnew_e,
        input logic [4:0] a3_m,
        input logic [1:0] tnew_m,
        input logic [4:0] a3_w
    );
        fwd_sel_d = FWD_NONE;
        if (src != 5'd0) begin
            if (src == a3_e) begin
                fwd_sel_d = (tnew_e == 2'd0) ? FWD_E : FWD_NONE;
            end else if (src == a3_m) begin
                fwd_sel_d = (tnew_m == 2'd0) ? FWD_M : FWD_NONE;
            end else if (src == a3_w) begin
                fwd_sel_d = FWD_W;
            end
        end
    endfunction

    function automatic logic [1:0] fwd_sel_e(
        input logic [4:0] src,
        input logic [4:0] a3_m,
        input logic [1:0] tnew_m,
        input logic [4:0] a3_w
    );
        fwd_sel_e = FWD_NONE;
        if (src != 5'd0) begin
            if (src == a3_m) begin
                fwd_sel_e = (tnew_m == 2'd0) ? FWD_M : FWD_NONE;
            end else if (src == a3_w) begin
                fwd_sel_e = FWD_W;
            end
        end
    endfunction

    always_comb begin
        fwd_rs_D = fwd_sel_d(A1_D, r_a3_e, r_tnew_e, r_a3_m, r_tnew_m, r_a3_w);
        fwd_rt_D = fwd_sel_d(A2_D, r_a3_e, r_tnew_e, r_a3_m, r_tnew_m, r_a3_w);
        fwd_rs_E = fwd_sel_e(r_a1_e, r_a3_m, r_tnew_m, r_a3_w);
        fwd_rt_E = fwd_sel_e(r_a2_e, r_a3_m, r_tnew_m, r_a3_w);
        // W results are always ready, so store data only needs an index match.
        fwd_rt_M = (r_a2_m != 5'd0) && (r_a2_m == r_a3_w);
    end

    // -----------------------------------------------------------------------
    // Pipeline state
    // -----------------------------------------------------------------------
    // E takes a bubble on stall; M and W always advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a1_e   <= 5'd0;
            r_a2_e   <= 5'd0;
            r_a3_e   <= 5'd0;
            r_tnew_e <= 2'd0;
        end else if (stall) begin
            r_a1_e   <= 5'd0;
            r_a2_e   <= 5'd0;
            r_a3_e   <= 5'd0;
            r_tnew_e <= 2'd0;
        end else begin
            r_a1_e   <= A1_D;
            r_a2_e   <= A2_D;
            r_a3_e   <= w_a3_eff;
            r_tnew_e <= tnew_D;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a2_m   <= 5'd0;
            r_a3_m   <= 5'd0;
            r_tnew_m <= 2'd0;
            r_a3_w   <= 5'd0;
        end else begin
            r_a2_m   <= r_a2_e;
            r_a3_m   <= r_a3_e;
            r_tnew_m <= w_tnew_m_next;
            r_a3_w   <= r_a3_m;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= 32'd0;
        end else if (stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl. Instruction sequences are driven one
// cycle at a time, 1 ns after each rising edge; outputs are checked at 2 ns,
// well clear of the next edge. Expected values are worked out by hand from
// the pipeline timing of each sequence.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  A1_D;
    logic [4:0]  A2_D;
    logic [4:0]  A3_D;
    logic        regwrite_D;
    logic [1:0]  tnew_D;
    logic        tuse_rs0;
    logic        tuse_rs1;
    logic        tuse_rt0;
    logic        tuse_rt1;
    logic        stall;
    logic [1:0]  fwd_rs_D;
    logic [1:0]  fwd_rt_D;
    logic [1:0]  fwd_rs_E;
    logic [1:0]  fwd_rt_E;
    logic        fwd_rt_M;
    logic [31:0] stall_cnt;

    int n_checks;
    int n_pass;

    hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .A1_D       (A1_D),
        .A2_D       (A2_D),
        .A3_D       (A3_D),
        .regwrite_D (regwrite_D),
        .tnew_D     (tnew_D),
        .tuse_rs0   (tuse_rs0),
        .tuse_rs1   (tuse_rs1),
        .tuse_rt0   (tuse_rt0),
        .tuse_rt1   (tuse_rt1),
        .stall      (stall),
        .fwd_rs_D   (fwd_rs_D),
        .fwd_rt_D   (fwd_rt_D),
        .fwd_rs_E   (fwd_rs_E),
        .fwd_rt_E   (fwd_rt_E),
        .fwd_rt_M   (fwd_rt_M),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    endtask

    // Drive the D-stage instruction fields.
    task automatic set_d(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                         input logic rw, input logic [1:0] tn, input logic rs0,
                         input logic rs1, input logic rt0, input logic rt1);
        A1_D = a1; A2_D = a2; A3_D = a3; regwrite_D = rw; tnew_D = tn;
        tuse_rs0 = rs0; tuse_rs1 = rs1; tuse_rt0 = rt0; tuse_rt1 = rt1;
        #1;
    endtask

    // Advance one clock; inputs may change 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " stall"},     {31'd0, stall},    32'd0);
        check({tag, " stall_cnt"}, stall_cnt,         32'd0);
        check({tag, " fwd_rs_D"},  {30'd0, fwd_rs_D}, 32'd0);
        check({tag, " fwd_rt_D"},  {30'd0, fwd_rt_D}, 32'd0);
        check({tag, " fwd_rs_E"},  {30'd0, fwd_rs_E}, 32'd0);
        check({tag, " fwd_rt_E"},  {30'd0, fwd_rt_E}, 32'd0);
        check({tag, " fwd_rt_M"},  {31'd0, fwd_rt_M}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state, with a D instruction that would hit nonzero indices
        step();
        set_d(5'd1, 5'd2, 5'd3, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        check_all_zero("reset");
        reset = 1'b0;
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // lw $1,0($29) followed by addu $2,$1,$3: one-cycle load-use stall
        step();
        set_d(5'd29, 5'd1, 5'd1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        check("lw stall", {31'd0, stall}, 32'd0);
        step();
        set_d(5'd1, 5'd3, 5'd2, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("lwuse stall c1", {31'd0, stall}, 32'd1);
        check("lwuse cnt c1", stall_cnt, 32'd0);
        step();
        check("lwuse stall c2", {31'd0, stall}, 32'd0);
        check("lwuse cnt c2", stall_cnt, 32'd1);
        step();
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lwuse fwd_rs_E", {30'd0, fwd_rs_E}, 32'd3);
        check("lwuse fwd_rt_E", {30'd0, fwd_rt_E}, 32'd0);
        check("lwuse cnt c3", stall_cnt, 32'd1);

        // Load-use stall again, then reset mid-cycle while stall is high
        step();
        set_d(5'd29, 5'd1, 5'd1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        set_d(5'd1, 5'd3, 5'd2, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("rst stall before", {31'd0, stall}, 32'd1);
        check("rst cnt before", stall_cnt, 32'd1);
        reset = 1'b1;
        #1;
        check_all_zero("rst async");
        step();
        check("rst held stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;
        #1;
        check("rst release stall", {31'd0, stall}, 32'd0);
        check("rst release cnt", stall_cnt, 32'd0);

        // addu $1 (tnew 1) then beq $1,$0: stall once, then forward from M
        pulse_reset();
        set_d(5'd2, 5'd3, 5'd1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        set_d(5'd1, 5'd0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("beq stall c1", {31'd0, stall}, 32'd1);
        step();
        check("beq stall c2", {31'd0, stall}, 32'd0);
        check("beq fwd_rs_D", {30'd0, fwd_rs_D}, 32'd2);
        check("beq fwd_rt_D", {30'd0, fwd_rt_D}, 32'd0);
        check("beq cnt", stall_cnt, 32'd1);

        // lw $0 then beq $0,$0: register 0 never hazards or forwards
        pulse_reset();
        set_d(5'd29, 5'd0, 5'd0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 2; c++) begin
            check("r0 stall", {31'd0, stall}, 32'd0);
            check("r0 fwd_rs_D", {30'd0, fwd_rs_D}, 32'd0);
            check("r0 fwd_rt_D", {30'd0, fwd_rt_D}, 32'd0);
            step();
        end

        // sw with A3=31 but no regwrite, then jr $31
        pulse_reset();
        set_d(5'd29, 5'd31, 5'd31, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        set_d(5'd31, 5'd0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("sw-jr stall", {31'd0, stall}, 32'd0);
        check("sw-jr fwd_rs_D", {30'd0, fwd_rs_D}, 32'd0);

        // ori $31 in M, jal (A3=31, tnew 0) in E, jr $31 in D: E wins
        pulse_reset();
        set_d(5'd5, 5'd31, 5'd31, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        set_d(5'd0, 5'd0, 5'd31, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        set_d(5'd31, 5'd0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("jal-jr stall", {31'd0, stall}, 32'd0);
        check("jal-jr fwd_rs_D", {30'd0, fwd_rs_D}, 32'd1);

        // lw $7 immediately followed by sw $7: store data forwarded in M from W
        pulse_reset();
        set_d(5'd29, 5'd7, 5'd7, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        set_d(5'd29, 5'd7, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lw-sw stall", {31'd0, stall}, 32'd0);
        step();
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lw-sw fwd_rt_M early", {31'd0, fwd_rt_M}, 32'd0);
        step();
        check("lw-sw fwd_rt_M", {31'd0, fwd_rt_M}, 32'd1);
        check("lw-sw fwd_rs_E", {30'd0, fwd_rs_E}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
